// File: rtl/vga_pixel_fetch.sv
// Prefetches display words from the ZBT frame buffer and answers VGA pixel-pair requests.
// Define VGA_FETCH_UNDERFLOW_COUNT_EN to add the saturating underflow_count output.
//   state | meaning
//   RUN   | fetch engine keeps the FIFO topped up from the display bank
//   FLUSH | frame restart: drain outstanding reads, discard their data
module vga_pixel_fetch #(
  parameter int WORDS_PER_FRAME = 153600,
  parameter int DEPTH           = 4,
  parameter int ADDR_W          = 19,
  parameter int READ_LATENCY    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_flag,
  input  logic              vga_active,
  input  logic              vga_frame_start,
  input  logic              frame_flag,
  output logic [35:0]       vga_pixel,
  output logic              done_vga,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [35:0]       mem_rdata,
  output logic              underflow,
`ifdef VGA_FETCH_UNDERFLOW_COUNT_EN
  output logic [15:0]       underflow_count,
`endif
  output logic              display_bank
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = ADDR_W - 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_n;
  logic [35:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt, fifo_cnt_n, outstanding, outstanding_n;
  logic [RW-1:0] rd_addr, rd_addr_n;
  logic          swap_pending, swap_pending_n, display_bank_n, mem_req_n, vga_flag_d;
  logic          req, ack_fire, rv_fire, discard, push, pop, empty_hit, wrap;

  if (READ_LATENCY < 1 || READ_LATENCY > DEPTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
  begin : g_bad_param
    $error("vga_pixel_fetch: DEPTH must be a power of 2 >= 2 and READ_LATENCY in 1..DEPTH");
  end

  assign req       = vga_flag & ~vga_flag_d;
  assign ack_fire  = mem_req & mem_ack;
  // Returns with nothing outstanding are stale reads from before a reset.
  assign rv_fire   = mem_rvalid & (outstanding != '0);
  assign discard   = (state == FLUSH) | vga_frame_start;
  assign push      = rv_fire & ~discard;
  assign pop       = req & vga_active & ~discard & (fifo_cnt != '0);
  assign empty_hit = req & vga_active & ~discard & (fifo_cnt == '0);
  assign wrap      = (rd_addr == RW'(WORDS_PER_FRAME - 1));

  always_comb begin
    state_n        = state;
    outstanding_n  = outstanding + CW'(ack_fire) - CW'(rv_fire);
    fifo_cnt_n     = fifo_cnt + CW'(push) - CW'(pop);
    rd_addr_n      = rd_addr;
    display_bank_n = display_bank;
    swap_pending_n = swap_pending | frame_flag;

    if (vga_frame_start) begin
      state_n = FLUSH;
    end else if (state == FLUSH && outstanding == '0) begin
      state_n = RUN;
    end

    if (vga_frame_start) begin
      fifo_cnt_n = '0;
      rd_addr_n  = '0;
    end else if (ack_fire) begin
      rd_addr_n = wrap ? '0 : rd_addr + RW'(1);
    end

    if ((vga_frame_start | (ack_fire & wrap)) & (swap_pending | frame_flag)) begin
      display_bank_n = ~display_bank;
      swap_pending_n = 1'b0;
    end

    // Credit counts both buffered words and reads still in flight so a return never overflows.
    mem_req_n = (state_n == RUN) &&
                (({1'b0, fifo_cnt_n} + {1'b0, outstanding_n}) < (CW + 1)'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      fifo_cnt     <= '0;
      outstanding  <= '0;
      rd_addr      <= '0;
      swap_pending <= 1'b0;
      display_bank <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      vga_flag_d   <= 1'b0;
      vga_pixel    <= '0;
      done_vga     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      state        <= state_n;
      fifo_cnt     <= fifo_cnt_n;
      outstanding  <= outstanding_n;
      rd_addr      <= rd_addr_n;
      swap_pending <= swap_pending_n;
      display_bank <= display_bank_n;
      mem_req      <= mem_req_n;
      mem_addr     <= {display_bank_n, rd_addr_n};
      vga_flag_d   <= vga_flag;
      done_vga     <= req;
      underflow    <= underflow | empty_hit;
      if (req) begin
        vga_pixel <= pop ? fifo_mem[rd_ptr] : '0;
      end
      if (vga_frame_start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

`ifdef VGA_FETCH_UNDERFLOW_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset || vga_frame_start) begin
      underflow_count <= '0;
    end else if (empty_hit && underflow_count != 16'hFFFF) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: a queue-level model predicts each response and fetch address.
// A short frame (WPF words) keeps bank-swap wraps within a small cycle budget.
module tb_vga_pixel_fetch;
  localparam int WPF   = 96;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, vga_flag, vga_active, vga_frame_start, frame_flag;
  logic [35:0] vga_pixel, mem_rdata;
  logic        done_vga, mem_req, mem_ack, mem_rvalid, underflow, display_bank;
  logic [18:0] mem_addr;
`ifdef VGA_FETCH_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_count;
`endif

  vga_pixel_fetch #(.WORDS_PER_FRAME(WPF), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .vga_flag(vga_flag), .vga_active(vga_active),
    .vga_frame_start(vga_frame_start), .frame_flag(frame_flag),
    .vga_pixel(vga_pixel), .done_vga(done_vga), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .underflow(underflow),
`ifdef VGA_FETCH_UNDERFLOW_COUNT_EN
    .underflow_count(underflow_count),
`endif
    .display_bank(display_bank)
  );

  always #5 clock = ~clock;

  typedef struct { logic [35:0] pix; logic uf; int cyc; } exp_t;
  typedef struct { int due; logic [35:0] data; } ret_t;

  exp_t        expq[$];
  ret_t        rq[$];
  logic [35:0] avail[$];

  int          total = 0, bad = 0;
  int          cyc = 0, last_due = 0, ack_mode = 0, lat = 2;
  int          out_m = 0, idx_m = 0, ufc_m = 0, ack_cnt = 0, done_cnt = 0;
  bit          flushing = 0, bank_m = 0, pend_m = 0, flag_prev = 0, uf_m = 0;
  bit          saw_bank1_zero = 0, capture = 0;
  bit          ack_s, rv_s;
  logic [18:0] addr_s, last_ack_addr = '0, fs_addr = '1;

  function automatic logic [35:0] word_of(input logic [18:0] a);
    return {a[17:0], ~a[17:0]} ^ 36'h5A5A5A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: advanced once per clock edge from the inputs that were applied to it.
  task automatic model_update();
    bit   req, fl_old, wrap;
    int   out_old, c0, due;
    exp_t e;
    ret_t r;
    c0 = cyc;
    cyc++;
    if (reset) begin
      flag_prev = 0; out_m = 0; flushing = 0; bank_m = 0; pend_m = 0; idx_m = 0;
      uf_m = 0; ufc_m = 0; last_due = 0;
      avail.delete(); rq.delete();
      return;
    end
    req       = vga_flag && !flag_prev;
    flag_prev = vga_flag;
    fl_old    = flushing;
    out_old   = out_m;
    wrap      = 0;
    if (req) begin
      e.pix = '0;
      if (!(vga_frame_start || fl_old) && vga_active) begin
        if (avail.size() > 0) e.pix = avail.pop_front();
        else begin
          uf_m = 1;
          if (ufc_m < 65535) ufc_m++;
        end
      end
      e.uf  = uf_m;
      e.cyc = cyc;
      expq.push_back(e);
    end
    if (vga_frame_start) begin
      avail.delete();
      ufc_m = 0;
    end
    if (rv_s) begin
      r = rq.pop_front();
      out_m--;
      if (!(vga_frame_start || fl_old)) begin
        avail.push_back(r.data);
        chk("fifo_no_overflow", avail.size() <= DEPTH, 1);
      end
    end
    if (ack_s) begin
      chk("mem_addr", addr_s, {bank_m, 18'(idx_m)});
      ack_cnt++;
      last_ack_addr = addr_s;
      if (capture) begin fs_addr = addr_s; capture = 0; end
      if (addr_s == 19'h40000) saw_bank1_zero = 1;
      out_m++;
      due = (c0 + lat > last_due) ? c0 + lat : last_due + 1;
      last_due = due;
      r.due  = due;
      r.data = word_of(addr_s);
      rq.push_back(r);
      wrap  = (idx_m == WPF - 1);
      idx_m = wrap ? 0 : idx_m + 1;
    end
    if (vga_frame_start) idx_m = 0;
    if ((vga_frame_start || (ack_s && wrap)) && (pend_m || frame_flag)) begin
      bank_m = ~bank_m;
      pend_m = 0;
    end else begin
      pend_m = pend_m | frame_flag;
    end
    if (vga_frame_start) flushing = 1;
    else if (fl_old && out_old == 0) flushing = 0;
    if (ack_s) chk("display_bank", display_bank, bank_m);
  endtask

  // One clock: the arbiter answers what the DUT shows now, then the model follows the edge.
  task automatic step();
    ack_s = 0; rv_s = 0; addr_s = mem_addr;
    mem_rdata = {4'($urandom_range(0, 15)), 32'($urandom)};
    if (!reset) begin
      case (ack_mode)
        0:       ack_s = mem_req;
        1:       ack_s = mem_req && ($urandom_range(0, 9) < 7);
        default: ack_s = 0;
      endcase
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rv_s = 1;
        mem_rdata = rq[0].data;
      end
    end
    mem_ack = ack_s; mem_rvalid = rv_s;
    @(posedge clock);
    #1;
    model_update();
    mem_ack = 0; mem_rvalid = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && done_vga) begin
        done_cnt++;
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: strobe with no request pending (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          chk("vga_pixel", vga_pixel, e.pix);
          chk("underflow", underflow, e.uf);
          chk("done_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : stim
    bit found;
    int d0;
    reset = 1; vga_flag = 0; vga_active = 0; vga_frame_start = 0; frame_flag = 0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (3) step();
    chk("rst_vga_pixel", vga_pixel, 0);
    chk("rst_done_vga", done_vga, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_display_bank", display_bank, 0);
    reset = 0;

    repeat (15) step();
    chk("init_req_count", ack_cnt, 4);
    chk("init_req_idle", mem_req, 0);

    vga_active = 1; vga_flag = 1; step(); vga_flag = 0;
    repeat (6) step();
    chk("refill_addr", last_ack_addr, 19'd4);
    chk("refill_count", ack_cnt, 5);

    d0 = done_cnt;
    vga_flag = 1; repeat (3) step(); vga_flag = 0;
    repeat (4) step();
    chk("held_flag_one_done", done_cnt - d0, 1);

    frame_flag = 1; step(); frame_flag = 0;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      vga_flag = (i % 4 == 0);
      step();
      found = saw_bank1_zero;
    end
    vga_flag = 0;
    chk("wrap_fetch_bank1_addr0", found, 1);
    repeat (2) step();
    chk("display_bank_after_wrap", display_bank, 1);

    repeat (8) step();
    chk("no_underflow_yet", underflow, 0);
    ack_mode = 2;
    for (int i = 0; i < 20; i++) begin
      vga_flag = (i % 2 == 0);
      step();
    end
    vga_flag = 0; step();
    chk("stall_underflow", underflow, 1);
`ifdef VGA_FETCH_UNDERFLOW_COUNT_EN
    chk("stall_underflow_count", underflow_count, ufc_m);
`endif
    ack_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      vga_flag        = ($urandom_range(0, 2) == 0);
      vga_active      = ($urandom_range(0, 9) != 0);
      frame_flag      = ($urandom_range(0, 149) == 0);
      vga_frame_start = ($urandom_range(0, 399) == 0);
      lat             = $urandom_range(1, DEPTH);
      step();
    end
    vga_flag = 0; frame_flag = 0; vga_frame_start = 0; vga_active = 1;
    ack_mode = 0; lat = 4;
    repeat (12) step();
`ifdef VGA_FETCH_UNDERFLOW_COUNT_EN
    chk("random_underflow_count", underflow_count, ufc_m);
`endif

    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      vga_flag = (i % 2 == 0);
      step();
      found = (out_m == 2);
    end
    vga_flag = 0;
    chk("flush_setup_two_outstanding", found, 1);
    vga_frame_start = 1; step(); vga_frame_start = 0;
    capture = 1;
    repeat (20) step();
    chk("flush_restart_addr", fs_addr, {bank_m, 18'h0});
    vga_flag = 1; step(); vga_flag = 0;
    chk("first_word_after_flush", vga_pixel, word_of({bank_m, 18'h0}));

    repeat (10) step();
    chk("scoreboard_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Sits directly upstream of the VGA write stage, in the system clock domain.
- Answers each VGA pixel-pair request (vga_flag) with a 36-bit word (two pixels) and a done_vga strobe.
- Prefetches words from the display frame buffer in ZBT memory through the memory arbiter's read port, with double-buffered bank selection.
- Swaps display bank at frame boundaries when the writer signals a completed frame.

Parameters:
- WORDS_PER_FRAME, 153600: 640x480 pixels at 2 pixels/word; the address wraps after this count.
- DEPTH, 4: prefetch FIFO depth in words (power of 2, ≥2).
- ADDR_W, 19: memory word address width; the MSB selects the bank.
- READ_LATENCY, 2: informational; returns are in order, and any latency of 1..DEPTH is tolerated.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- vga_flag  in  1  pixel-pair request from VGA write; single-cycle pulse, rising-edge detected
- vga_active  in  1  level, high while the VGA stage is in the visible region
- vga_frame_start  in  1  one-cycle pulse at the VGA frame start (before first visible line)
- frame_flag  in  1  one-cycle pulse: writer finished the frame in the back bank
- vga_pixel  out  36  pixel pair; [35:28] and [17:10] carry the luma bytes
- done_vga  out  1  one-cycle strobe; vga_pixel valid from this cycle until the next strobe
- mem_req  out  1  read request, held until accepted
- mem_addr  out  ADDR_W  read word address, stable while mem_req is high
- mem_ack  in  1  arbiter accepted the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  36  read data, returned in request order
- underflow  out  1  sticky: a visible request found the FIFO empty
- display_bank  out  1  bank currently displayed

Behaviour:
- Reset values:
  - Outputs: vga_pixel=0, done_vga=0, mem_req=0, mem_addr=0, underflow=0, display_bank=0.
  - Internal: FIFO empty, outstanding=0, rd_addr=0, swap_pending=0, state RUN.
- Reset mid-transaction: pending reads are abandoned, and any mem_rvalid after reset is ignored until the first mem_req issues.
- Request detect: req = vga_flag & ~vga_flag_d. A flag held for several cycles counts as one request.
- Response timing:
  - On req, done_vga and vga_pixel update on the next clock edge (latency 1), so data is valid ≤2 cycles after the flag.
  - If vga_active=1 and the FIFO is non-empty: pop the head into vga_pixel.
  - If vga_active=1 and the FIFO is empty: vga_pixel=0, set underflow, rd_addr unchanged.
  - If vga_active=0: vga_pixel=0, no pop. done_vga is still strobed in every case.
- Fetch engine (state RUN):
  - Raise mem_req when occupancy + outstanding < DEPTH.
  - mem_addr = {display_bank, rd_addr[ADDR_W-2:0]}.
  - On mem_ack: outstanding+1 and rd_addr+1. rd_addr wraps WORDS_PER_FRAME-1 → 0.
  - mem_req may re-assert in the cycle after ack if credit remains.
  - On mem_rvalid: push mem_rdata, outstanding-1.
  - A simultaneous ack and rvalid leaves outstanding unchanged.
  - A simultaneous push and pop leaves occupancy unchanged. A push into a full FIFO cannot occur by construction; the bench asserts it.
- Bank swap:
  - frame_flag sets swap_pending.
  - At the rd_addr wrap (ack of the last word), if swap_pending: toggle display_bank and clear swap_pending. The next word already uses the new bank.
  - A frame_flag coinciding with the wrap ack is applied at this wrap.
  - Multiple frame_flags before a wrap equal one swap.
- States:
  - RUN: fetch engine as above.
  - FLUSH:
    - Entered on vga_frame_start: mem_req drops the same edge, the FIFO is cleared, rd_addr=0, and a pending swap is applied immediately.
    - In FLUSH, mem_rvalid data is discarded (outstanding-1), and requests answer with 0 and no pop.
    - Exit to RUN when outstanding==0.
  - vga_frame_start during FLUSH restarts FLUSH, with no further effect.
- Underflow is cleared only by reset.

Optional Feature:
- VGA_FETCH_UNDERFLOW_COUNT_EN defined: adds output underflow_count[15:0].
  - Increments on each visible empty-FIFO request and saturates at 16'hFFFF.
  - Reset to 0, and also cleared on vga_frame_start.
- Undefined: port and counter absent; only the sticky underflow exists.

Test Plan:
- Reset, then an arbiter that acks immediately with READ_LATENCY=2 and rdata=address:
  - Exactly 4 requests are issued (addr 0..3), then mem_req stays low.
- vga_active=1, pulse vga_flag once:
  - The next cycle shows done_vga=1 and vga_pixel=0.
  - The refill request to addr 4 follows.
- vga_flag held high 3 cycles: exactly one done_vga and one pop.
- Stream 153600 visible requests with frame_flag pulsed mid-frame:
  - The word after the wrap is fetched from addr 19'h40000, and display_bank=1.
- Arbiter stalls mem_ack for 20 cycles while requests continue:
  - underflow=1, vga_pixel=0 on empty pops.
  - With the optional feature, underflow_count matches the number of empty visible requests.
- vga_frame_start with 2 reads outstanding:
  - Both returns are discarded, and the next request goes to addr {bank,0}.
  - The first visible request after the refill returns word 0.
